// File: rtl/sdio_pkg.sv
//------------------------------------------------------------------------------
// Module : sdio_pkg
// Brief  : Shared SDIO bus-width encodings and width clipping helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sdio_pkg;

  localparam logic [1:0] c_width_1 = 2'd0;
  localparam logic [1:0] c_width_4 = 2'd1;
  localparam logic [1:0] c_width_8 = 2'd2;

  // Reserved code 3 folds into 8-bit, then the lane count caps the result.
  function automatic logic [1:0] clip_width(input logic [1:0] cfg, input int numio);
    logic [1:0] w;
    if (cfg == c_width_1)      w = c_width_1;
    else if (cfg == c_width_4) w = c_width_4;
    else                       w = c_width_8;
    if (numio < 4)                          w = c_width_1;
    else if ((numio < 8) && (w == c_width_8)) w = c_width_4;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdio_rxgear_sfifo.sv
//------------------------------------------------------------------------------
// Module : sfifo
// Brief  : Synchronous FIFO with write-through-when-popping at full.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sfifo #(
  parameter int DW      = 32,
  parameter int LGDEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [DW-1:0]    i_data,
  input  logic             i_rd,
  output logic             o_full,
  output logic             o_empty,
  output logic [LGDEPTH:0] o_fill,
  output logic [DW-1:0]    o_data
);

  localparam int c_depth = 1 << LGDEPTH;

  logic [DW-1:0]      r_mem [0:c_depth-1];
  logic [LGDEPTH-1:0] r_wptr;
  logic [LGDEPTH-1:0] r_rptr;
  logic [LGDEPTH:0]   r_fill;
  logic               w_rd;
  logic               w_wr;

  assign o_empty = (r_fill == '0);
  assign o_full  = (r_fill == (LGDEPTH+1)'(c_depth));
  assign w_rd    = i_rd && !o_empty;
  // A full FIFO still takes a word when a slot frees up this same cycle.
  assign w_wr    = i_wr && (!o_full || w_rd);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_fill <= r_fill + {{LGDEPTH{1'b0}}, w_wr} - {{LGDEPTH{1'b0}}, w_rd};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_clr) r_mem[r_wptr] <= i_data;
  end

  assign o_fill = r_fill;
  assign o_data = o_empty ? '0 : r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/sdio_rxgear.sv
//------------------------------------------------------------------------------
// Module : sdio_rxgear
// Brief  : SDIO receive gearbox packing 1/4/8-bit SDR/DDR beats into MW words.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sdio_rxgear
  import sdio_pkg::*;
#(
  parameter int NUMIO             = 8,
  parameter int MW                = 32,
  parameter int LGDEPTH           = 3,
  parameter int OPT_LITTLE_ENDIAN = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_cfg_width,
  input  logic             i_flush,
  input  logic [1:0]       i_rx_strb,
  input  logic [15:0]      i_rx_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [MW-1:0]    o_data,
  output logic [LGDEPTH:0] o_fill,
  output logic             o_overflow
);

  localparam int c_fw = $clog2(MW) + 1;

  logic [1:0]      r_width;
  logic [MW-1:0]   r_acc;
  logic [c_fw-1:0] r_fill;
  logic            r_overflow;
  logic [MW-1:0]   w_acc_nxt;
  logic [c_fw-1:0] w_fill_nxt;
  logic [c_fw-1:0] w_step;
  logic [c_fw-1:0] w_pad;
  logic [MW-1:0]   w_word;
  logic [MW-1:0]   w_fifo_data;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_drop;

  function automatic logic [MW-1:0] shift_in(input logic [MW-1:0] acc,
                                             input logic [7:0] b,
                                             input logic [1:0] wd);
    case (wd)
      c_width_1: return {acc[MW-2:0], b[0]};
      c_width_4: return {acc[MW-5:0], b[3:0]};
      default:   return {acc[MW-9:0], b};
    endcase
  endfunction

  always_comb begin
    case (r_width)
      c_width_1: w_step = c_fw'(1);
      c_width_4: w_step = c_fw'(4);
      default:   w_step = c_fw'(8);
    endcase
  end

  // Each beat is checked for completion on its own so odd single-beat runs
  // still close a word exactly at MW bits.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_fill_nxt = r_fill;
    w_push     = 1'b0;
    w_word     = '0;
    w_pad      = '0;
    if (i_rx_strb[1]) begin
      w_acc_nxt  = shift_in(w_acc_nxt, i_rx_data[15:8], r_width);
      w_fill_nxt = w_fill_nxt + w_step;
    end
    if (w_fill_nxt == c_fw'(MW)) begin
      w_push     = 1'b1;
      w_word     = w_acc_nxt;
      w_acc_nxt  = '0;
      w_fill_nxt = '0;
    end
    if (i_rx_strb[0]) begin
      w_acc_nxt  = shift_in(w_acc_nxt, i_rx_data[7:0], r_width);
      w_fill_nxt = w_fill_nxt + w_step;
    end
    if (w_fill_nxt == c_fw'(MW)) begin
      w_push     = 1'b1;
      w_word     = w_acc_nxt;
      w_acc_nxt  = '0;
      w_fill_nxt = '0;
    end
    if (i_flush && !w_push && (w_fill_nxt != '0)) begin
      w_pad      = c_fw'(MW) - w_fill_nxt;
      w_push     = 1'b1;
      w_word     = w_acc_nxt << w_pad;
      w_acc_nxt  = '0;
      w_fill_nxt = '0;
    end
  end

  assign w_pop  = !w_empty && i_ready;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_width    <= c_width_1;
      r_acc      <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else if (!i_en) begin
      r_width    <= clip_width(i_cfg_width, NUMIO);
      r_acc      <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_acc      <= w_drop ? '0 : w_acc_nxt;
      r_fill     <= w_drop ? '0 : w_fill_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  sfifo #(
    .DW      (MW),
    .LGDEPTH (LGDEPTH)
  ) u_sfifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (!i_en),
    .i_wr    (w_push && i_en),
    .i_data  (w_word),
    .i_rd    (i_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (o_fill),
    .o_data  (w_fifo_data)
  );

  assign o_valid    = !w_empty;
  assign o_overflow = r_overflow;

  if (OPT_LITTLE_ENDIAN != 0) begin : g_le
    for (genvar i = 0; i < MW/8; i++) begin : g_byte
      assign o_data[8*i +: 8] = w_fifo_data[MW-8-8*i +: 8];
    end
  end else begin : g_be
    assign o_data = w_fifo_data;
  end

endmodule

`default_nettype wire
